// File: rtl/gray_step_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : gray_step_ctrl
//  Description : Command-driven sequencer for an external N-bit Gray counter.
//                Issues an optional clear followed by K prescaled clock-enable
//                pulses, and watches the counter output for illegal
//                transitions (sticky err flag).
//  Revision    : 1.0 - initial release
// ============================================================================
module gray_step_ctrl #(
   parameter int N  = 4,
   parameter int SW = 16,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [SW-1:0] cmd_steps,
   input  logic [DW-1:0] cmd_div,
   input  logic          cmd_clear,
   input  logic          abort,
   input  logic          err_clr,
   input  logic [N-1:0]  gray_in,
   output logic          cnt_en,
   output logic          cnt_clr,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [SW-1:0] steps_left,
   output logic [N-1:0]  pos_bin
);

   localparam logic [2:0] c_ST_IDLE   = 3'd0;
   localparam logic [2:0] c_ST_CLEAR  = 3'd1;
   localparam logic [2:0] c_ST_RUN    = 3'd2;
   localparam logic [2:0] c_ST_SETTLE = 3'd3;
   localparam logic [2:0] c_ST_DONE   = 3'd4;

   localparam logic [SW-1:0] c_STEP_ONE  = SW'(1);
   localparam logic [DW-1:0] c_PRESC_ONE = DW'(1);
   localparam logic [N-1:0]  c_GRAY_ONE  = N'(1);

   // FSM and datapath registers
   logic [2:0]    r_state;
   logic [DW-1:0] r_div;
   logic [DW-1:0] r_presc;
   logic          r_cnt_en;
   logic          r_cnt_clr;
   logic [SW-1:0] r_steps_left;

   // Monitor registers
   logic [N-1:0]  r_gray_prev;
   logic          r_en_d;
   logic          r_clr_d;
   logic          r_armed;
   logic          r_err;
   logic [N-1:0]  r_pos_bin;

   // Combinational next values
   logic [2:0]    w_state_nxt;
   logic          w_cnt_en_nxt;
   logic          w_cnt_clr_nxt;
   logic [SW-1:0] w_steps_nxt;
   logic [DW-1:0] w_presc_nxt;
   logic [DW-1:0] w_div_nxt;
   logic          w_presc_hit;
   logic          w_last_step;
   logic [N-1:0]  w_gray_diff;
   logic          w_mon_fail;
   logic [N-1:0]  w_pos_bin;

   // Prescaler reaches the programmed divider: this edge issues a pulse
   assign w_presc_hit = (r_presc == r_div);
   assign w_last_step = (r_steps_left == c_STEP_ONE);

   assign cmd_ready  = (r_state == c_ST_IDLE);
   assign busy       = (r_state != c_ST_IDLE);
   assign done       = (r_state == c_ST_DONE);
   assign cnt_en     = r_cnt_en;
   assign cnt_clr    = r_cnt_clr;
   assign steps_left = r_steps_left;
   assign err        = r_err;
   assign pos_bin    = r_pos_bin;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode; abort only matters while a command is in flight
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE: begin
            if (cmd_valid) begin
               if (cmd_clear)
                  w_state_nxt = c_ST_CLEAR;
               else if (cmd_steps == '0)
                  w_state_nxt = c_ST_DONE;
               else
                  w_state_nxt = c_ST_RUN;
            end
         end
         c_ST_CLEAR: begin
            if (abort)
               w_state_nxt = c_ST_IDLE;
            else if (r_steps_left == '0)
               w_state_nxt = c_ST_DONE;
            else
               w_state_nxt = c_ST_RUN;
         end
         c_ST_RUN: begin
            if (abort)
               w_state_nxt = c_ST_IDLE;
            else if (w_presc_hit && w_last_step)
               w_state_nxt = c_ST_SETTLE;
         end
         c_ST_SETTLE: begin
            if (abort)
               w_state_nxt = c_ST_IDLE;
            else
               w_state_nxt = c_ST_DONE;
         end
         c_ST_DONE: begin
            w_state_nxt = c_ST_IDLE;
         end
         default: begin
            w_state_nxt = c_ST_IDLE;
         end
      endcase
   end

   // Next values of the registered counter controls and step bookkeeping
   always_comb begin
      w_cnt_en_nxt  = 1'b0;
      w_cnt_clr_nxt = 1'b0;
      w_steps_nxt   = r_steps_left;
      w_presc_nxt   = r_presc;
      w_div_nxt     = r_div;
      case (r_state)
         c_ST_IDLE: begin
            if (cmd_valid) begin
               w_steps_nxt   = cmd_steps;
               w_div_nxt     = cmd_div;
               w_cnt_clr_nxt = cmd_clear;
               w_presc_nxt   = '0;
            end
         end
         c_ST_CLEAR: begin
            if (!abort)
               w_presc_nxt = '0;
         end
         c_ST_RUN: begin
            if (!abort) begin
               if (w_presc_hit) begin
                  w_cnt_en_nxt = 1'b1;
                  w_presc_nxt  = '0;
                  w_steps_nxt  = r_steps_left - c_STEP_ONE;
               end else begin
                  w_presc_nxt  = r_presc + c_PRESC_ONE;
               end
            end
         end
         default: begin
         end
      endcase
   end

   // Datapath registers driven by the output decode
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt_en     <= 1'b0;
         r_cnt_clr    <= 1'b0;
         r_steps_left <= '0;
         r_presc      <= '0;
         r_div        <= '0;
      end else begin
         r_cnt_en     <= w_cnt_en_nxt;
         r_cnt_clr    <= w_cnt_clr_nxt;
         r_steps_left <= w_steps_nxt;
         r_presc      <= w_presc_nxt;
         r_div        <= w_div_nxt;
      end
   end

   assign w_gray_diff = gray_in ^ r_gray_prev;

   // Transition legality: cleared -> zero, stepped -> one bit flip, else stable
   always_comb begin
      w_mon_fail = 1'b0;
      if (r_armed) begin
         if (r_clr_d)
            w_mon_fail = (gray_in != '0);
         else if (r_en_d)
            w_mon_fail = (w_gray_diff == '0) ||
                         ((w_gray_diff & (w_gray_diff - c_GRAY_ONE)) != '0);
         else
            w_mon_fail = (w_gray_diff != '0);
      end
   end

   // Gray to binary: bit i is the XOR of all Gray bits at or above i
   always_comb begin
      w_pos_bin = '0;
      for (int i = 0; i < N; i++) begin
         w_pos_bin[i] = ^(gray_in >> i);
      end
   end

   // Monitor history, sticky error and registered position
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gray_prev <= '0;
         r_en_d      <= 1'b0;
         r_clr_d     <= 1'b0;
         r_armed     <= 1'b0;
         r_err       <= 1'b0;
         r_pos_bin   <= '0;
      end else begin
         r_gray_prev <= gray_in;
         r_en_d      <= r_cnt_en;
         r_clr_d     <= r_cnt_clr;
         r_armed     <= 1'b1;
         r_pos_bin   <= w_pos_bin;
         if (w_mon_fail)
            r_err <= 1'b1;
         else if (err_clr)
            r_err <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_gray_step_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gray_step_ctrl
//  Description : Self-checking bench for gray_step_ctrl with a behavioural
//                Gray counter attached to cnt_en / cnt_clr.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_step_ctrl;

   localparam int N  = 4;
   localparam int SW = 16;
   localparam int DW = 8;

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_clear = 1'b0;
   logic          abort     = 1'b0;
   logic          err_clr   = 1'b0;
   logic [SW-1:0] cmd_steps = '0;
   logic [DW-1:0] cmd_div   = '0;
   logic [N-1:0]  gray_in;
   logic          cmd_ready;
   logic          cnt_en;
   logic          cnt_clr;
   logic          busy;
   logic          done;
   logic          err;
   logic [SW-1:0] steps_left;
   logic [N-1:0]  pos_bin;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_pos  = 0;

   logic [N-1:0] cnt_bin;
   logic         fault_on  = 1'b0;
   logic [N-1:0] fault_val = '0;

   typedef struct {
      int steps;
      int div;
      bit clr;
      int exp_done;
      int exp_pulses;
      int exp_pos;
   } vec_t;

   vec_t tbl [7];

   gray_step_ctrl #(.N(N), .SW(SW), .DW(DW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_steps  (cmd_steps),
      .cmd_div    (cmd_div),
      .cmd_clear  (cmd_clear),
      .abort      (abort),
      .err_clr    (err_clr),
      .gray_in    (gray_in),
      .cnt_en     (cnt_en),
      .cnt_clr    (cnt_clr),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .steps_left (steps_left),
      .pos_bin    (pos_bin)
   );

   always #5 clk = ~clk;

   // External Gray counter: binary count, Gray view on gray_in (with fault override)
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_bin <= '0;
      else if (cnt_clr)
         cnt_bin <= '0;
      else if (cnt_en)
         cnt_bin <= N'(cnt_bin + 1'b1);
   end

   assign gray_in = fault_on ? fault_val : (cnt_bin ^ (cnt_bin >> 1));

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one command from IDLE and check every cycle against closed-form timing
   task automatic run_cmd(input int steps, input int div, input bit clr,
                          input bit abort_in_idle,
                          output int done_seen, output int pulses_seen);
      int r;
      int period;
      int done_edge;
      int fired;
      r         = clr ? 1 : 0;
      period    = div + 1;
      done_edge = (steps == 0) ? r : r + steps * period + 1;
      done_seen   = -1;
      pulses_seen = 0;
      cmd_steps = SW'(steps);
      cmd_div   = DW'(div);
      cmd_clear = clr;
      abort     = abort_in_idle;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      abort     = 1'b0;
      cmd_steps = SW'($urandom);
      cmd_div   = DW'($urandom);
      cmd_clear = 1'($urandom);
      for (int t = 0; t <= done_edge + 1; t++) begin
         if (t > 0)
            tick();
         fired = (steps > 0 && t > r) ? (t - r) / period : 0;
         if (fired > steps)
            fired = steps;
         check("cnt_en", cnt_en,
               (steps > 0 && t > r && (t - r) % period == 0 && (t - r) / period <= steps));
         check("cnt_clr", cnt_clr, (clr && t == 0));
         check("done", done, (t == done_edge));
         check("busy", busy, (t <= done_edge));
         check("cmd_ready", cmd_ready, (t > done_edge));
         check("steps_left", steps_left, steps - fired);
         if (cnt_en)
            pulses_seen++;
         if (done && done_seen < 0)
            done_seen = t;
      end
      exp_pos = ((clr ? 0 : exp_pos) + steps) % (1 << N);
      check("pos_bin", pos_bin, exp_pos);
      check("err", err, 0);
   endtask

   initial begin
      int ds;
      int ps;
      int gap;
      int rs;
      int rd;
      int rc;

      tbl[0] = '{5,  0, 1'b0, 6,  5,  5};
      tbl[1] = '{3,  2, 1'b1, 11, 3,  3};
      tbl[2] = '{20, 0, 1'b1, 22, 20, 4};
      tbl[3] = '{0,  0, 1'b0, 0,  0,  4};
      tbl[4] = '{0,  7, 1'b1, 1,  0,  0};
      tbl[5] = '{1,  3, 1'b0, 5,  1,  1};
      tbl[6] = '{16, 0, 1'b0, 17, 16, 1};

      // Reset state
      repeat (3) tick();
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_cnt_en", cnt_en, 0);
      check("rst_cnt_clr", cnt_clr, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_steps_left", steps_left, 0);
      check("rst_pos_bin", pos_bin, 0);
      rst_n = 1'b1;
      repeat (2) tick();

      // Table of commands with hand-computed outcomes
      for (int i = 0; i < 7; i++) begin
         run_cmd(tbl[i].steps, tbl[i].div, tbl[i].clr, 1'b0, ds, ps);
         check("tbl_done_edge", ds, tbl[i].exp_done);
         check("tbl_pulses", ps, tbl[i].exp_pulses);
         check("tbl_pos_bin", pos_bin, tbl[i].exp_pos);
      end

      // Abort after the 4th pulse of a 10-step, div=1 command
      cmd_steps = SW'(10);
      cmd_div   = DW'(1);
      cmd_clear = 1'b0;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      repeat (8) tick();
      check("abort_pre_steps", steps_left, 6);
      check("abort_pre_en", cnt_en, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_ready", cmd_ready, 1);
      check("abort_steps", steps_left, 6);
      check("abort_en", cnt_en, 0);
      check("abort_clr", cnt_clr, 0);
      check("abort_done", done, 0);
      exp_pos = (exp_pos + 4) % (1 << N);
      for (int k = 0; k < 4; k++) begin
         tick();
         check("abort_no_done", done, 0);
         check("abort_hold_steps", steps_left, 6);
      end
      check("abort_pos", pos_bin, exp_pos);
      check("abort_err", err, 0);

      // Zero-step command and abort held high while IDLE accepts
      run_cmd(0, 0, 1'b0, 1'b0, ds, ps);
      check("zero_done_edge", ds, 0);
      run_cmd(2, 0, 1'b0, 1'b1, ds, ps);
      check("idle_abort_done_edge", ds, 3);

      // Monitor: 2-bit flip while idle, stickiness, clear, and clear-vs-fail
      check("mon_pre_err", err, 0);
      fault_val = gray_in ^ 4'b0101;
      fault_on  = 1'b1;
      tick();
      check("mon_flip_err", err, 1);
      fault_on = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("mon_sticky", err, 1);
      end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("mon_cleared", err, 0);
      fault_val = gray_in ^ 4'b0001;
      fault_on  = 1'b1;
      err_clr   = 1'b1;
      tick();
      check("mon_fail_wins", err, 1);
      err_clr  = 1'b0;
      fault_on = 1'b0;
      tick();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("mon_cleared2", err, 0);
      tick();
      check("mon_stays_clear", err, 0);
      check("mon_pos", pos_bin, exp_pos);

      // Randomised commands against the timing model
      for (int n = 0; n < 12; n++) begin
         gap = $urandom_range(0, 3);
         repeat (gap) tick();
         rs = $urandom_range(0, 20);
         rd = $urandom_range(0, 3);
         rc = $urandom_range(0, 1);
         run_cmd(rs, rd, rc[0], 1'b0, ds, ps);
         check("rnd_pulses", ps, rs);
      end

      // Asynchronous reset in the middle of a run
      cmd_steps = SW'(10);
      cmd_div   = DW'(0);
      cmd_clear = 1'b0;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      repeat (3) tick();
      check("mid_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("arst_cnt_en", cnt_en, 0);
      check("arst_cnt_clr", cnt_clr, 0);
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      check("arst_err", err, 0);
      check("arst_steps", steps_left, 0);
      check("arst_ready", cmd_ready, 1);
      tick();
      rst_n   = 1'b1;
      exp_pos = 0;
      repeat (2) tick();
      run_cmd(3, 0, 1'b0, 1'b0, ds, ps);
      check("post_rst_done_edge", ds, 4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
